mod_div_responder: RTL
======================

MOD_DIV_RESPONDER -- requirements
Module: mod_div_responder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request level from requester; held high until ready seen, then dropped.
REQ-005 dividend  input  WIDTH  numerator, sampled only at request accept.
REQ-006 divider  input  WIDTH  denominator, sampled only at request accept.
REQ-007 quotient  output  WIDTH  registered floor(dividend/divider).
REQ-008 remainder  output  WIDTH  registered dividend mod divider.
REQ-009 ready  output  1  result valid; four-phase handshake acknowledge.
REQ-010 busy  output  1  high while a request is being processed (CALC or DONE).
REQ-011 div_by_zero  output  1  high with ready when accepted divider was 0.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start sampled high and start_seen_low set -> capture dividend/divider, clear quotient/remainder/div_by_zero, go CALC (or DONE if divider==0).
REQ-014 start_seen_low SHALL be set whenever start is sampled low and cleared on accept; a start held high from a prior transaction SHALL NOT trigger a new one.
REQ-015 CALC SHALL run restoring division, one quotient bit per cycle, MSB first, exactly WIDTH cycles, using a WIDTH+1-bit partial remainder.
REQ-016 Per step: partial = {partial, next dividend bit}; if partial >= divider subtract and shift in 1, else shift in 0.
REQ-017 After the WIDTH-th step the FSM SHALL enter DONE with quotient/remainder loaded.
REQ-018 Latency: accept at edge N -> ready high after edge N+WIDTH+1 (17 cycles at WIDTH=16).
REQ-019 Divider==0: enter DONE at edge N+1; quotient all ones, remainder = dividend, div_by_zero=1.
REQ-020 DONE: ready=1; state SHALL remain DONE while start sampled high; start sampled low -> ready=0, IDLE next edge.
REQ-021 If start is already low on DONE entry, ready SHALL be high for exactly one cycle.
REQ-022 Start dropping during CALC SHALL NOT abort the computation.
REQ-023 Input changes on dividend/divider after accept SHALL NOT affect the result.
REQ-024 quotient, remainder, div_by_zero SHALL hold stable from DONE entry until the next accept.
REQ-025 busy SHALL be 1 in CALC and DONE, 0 in IDLE.
REQ-026 Minimum turnaround: next accept no earlier than the first edge after returning to IDLE with start low then high.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0, start_seen_low=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation; no ready pulse after release until a new full handshake.
REQ-029 After rst release, start SHALL be sampled low at least once before the first accept.

Verification
REQ-030 WIDTH=16, 100/7 -> quotient=14, remainder=2, div_by_zero=0, ready 17 cycles after accept.
REQ-031 0xFFFF/1 -> quotient=0xFFFF, remainder=0; 3/9 -> quotient=0, remainder=3.
REQ-032 5/0 -> ready one cycle after accept, quotient=0xFFFF, remainder=5, div_by_zero=1.
REQ-033 start held high 10 cycles past ready -> ready stays high, busy=1, no second computation; start low -> ready=0 next edge.
REQ-034 rst asserted 5 cycles into CALC of 1000/3 -> all outputs 0 immediately; after release and new 1000/3 request -> quotient=333, remainder=1.
REQ-035 Randomized back-to-back requests (operands changed during CALC) vs. reference model -> every quotient/remainder matches accepted operands.

Source files
------------

// File: rtl/mod_div_responder.sv
// Restoring divider behind a four-phase start/ready handshake.
// One quotient bit per cycle, MSB first. Divide-by-zero short-circuits to a saturated result.
module mod_div_responder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is accepted on a rising edge where start is high
    // and start has been seen low since the previous accept (or since reset).
    // ready rises on DONE entry and holds until start is sampled low, after
    // which the block returns to IDLE on that same edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;
    logic             dz_pending_q, dz_pending_d;
    logic             seen_low_q, seen_low_d;
    logic [WIDTH:0]   partial;

    always_comb begin
        state_d      = state_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        part_d       = part_q;
        cnt_d        = cnt_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        ready_d      = ready_q;
        dz_d         = dz_q;
        dz_pending_d = dz_pending_q;
        seen_low_d   = seen_low_q;
        partial      = '0;

        if (!start) begin
            seen_low_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && seen_low_q) begin
                    seen_low_d   = 1'b0;
                    dvd_d        = dividend;
                    dvs_d        = divider;
                    part_d       = '0;
                    cnt_d        = '0;
                    quot_d       = '0;
                    rem_d        = '0;
                    dz_d         = 1'b0;
                    dz_pending_d = (divider == '0);
                    state_d      = CALC;
                end
            end
            CALC: begin
                // The zero-divisor case still spends one cycle here so DONE
                // is entered on the edge after accept.
                if (dz_pending_q) begin
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dz_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST_STEP) begin
                    quot_d  = dvd_q;
                    rem_d   = part_q;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    // dvd_q shifts left; vacated LSBs collect quotient bits.
                    partial = {part_q, dvd_q[WIDTH-1]};
                    if (partial >= {1'b0, dvs_q}) begin
                        partial = partial - {1'b0, dvs_q};
                        dvd_d   = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    part_d = partial[WIDTH-1:0];
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!start) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dvd_q        <= '0;
            dvs_q        <= '0;
            part_q       <= '0;
            cnt_q        <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            dz_q         <= 1'b0;
            dz_pending_q <= 1'b0;
            seen_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            part_q       <= part_d;
            cnt_q        <= cnt_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            dz_q         <= dz_d;
            dz_pending_q <= dz_pending_d;
            seen_low_q   <= seen_low_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign div_by_zero = dz_q;
    assign dbg_state   = state_q;

endmodule
